// File: rtl/cpu32_pkg.sv
// Shared cpu32 definitions: opcodes, control bundle layout and write-back source encodings.
package cpu32_pkg;

  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_ALUI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_B    = 4'd4;

  typedef enum logic [1:0] {
    WSRC_ALU  = 2'b00,
    WSRC_RAM  = 2'b01,
    WSRC_PC4  = 2'b10,
    WSRC_ZERO = 2'b11
  } wsrc_e;

  typedef struct packed {
    logic  alu_pc;
    logic  alu_imm;
    logic  regs_we;
    logic  ram_we;
    logic  alu_altdest;
    logic  branch_op;
    wsrc_e wdata_src;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: control bundle plus illegal-opcode flag.
module control_decode
  import cpu32_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_ALU: begin
        ctrl_o.regs_we   = 1'b1;
        ctrl_o.wdata_src = WSRC_ALU;
      end
      OP_ALUI: begin
        ctrl_o.alu_imm   = 1'b1;
        ctrl_o.regs_we   = 1'b1;
        ctrl_o.wdata_src = WSRC_ALU;
      end
      OP_LW: begin
        ctrl_o.alu_imm   = 1'b1;
        ctrl_o.regs_we   = 1'b1;
        ctrl_o.wdata_src = WSRC_RAM;
      end
      OP_SW: begin
        ctrl_o.alu_imm   = 1'b1;
        ctrl_o.ram_we    = 1'b1;
        ctrl_o.wdata_src = WSRC_ZERO;
      end
      OP_B: begin
        ctrl_o.alu_pc    = 1'b1;
        ctrl_o.alu_imm   = 1'b1;
        ctrl_o.regs_we   = 1'b1;
        ctrl_o.branch_op = 1'b1;
        ctrl_o.wdata_src = WSRC_PC4;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined cpu32 control: D-slot decode, registered E slot, branch resolution,
// load-use interlock and RAM wait timeout.
module control_pipe
  import cpu32_pkg::*;
#(
  parameter int unsigned RA_W        = 4,
  parameter bit          HAZARD_EN   = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      opcode,
  input  logic [3:0]      opfunc,
  input  logic [RA_W-1:0] opd,
  input  logic [RA_W-1:0] opa,
  input  logic [RA_W-1:0] opb,
  input  logic            adata_zero,
  input  logic            mem_ready,
  output logic            e_valid,
  output logic            e_alu_pc,
  output logic            e_alu_imm,
  output logic            e_regs_we,
  output logic            e_ram_we,
  output logic            e_alu_altdest,
  output logic [1:0]      e_wdata_src,
  output logic [RA_W-1:0] e_waddr,
  output logic            branch_taken,
  output logic            branch_ind,
  output logic            stall,
  output logic            illegal,
  output logic            mem_fault
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(MEM_TIMEOUT);

  ctrl_t           dec_ctrl;
  logic            dec_illegal;

  logic            e_valid_q, e_valid_d;
  ctrl_t           e_ctrl_q, e_ctrl_d;
  logic [RA_W-1:0] e_waddr_q, e_waddr_d;
  logic            e_nz_q, e_nz_d;
  logic            e_ind_q, e_ind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;
  logic            illegal_q, illegal_d;

  logic e_is_lw, e_is_mem, timeout, mem_wait, src_hit, hazard, take;

  control_decode u_decode (
    .opcode_i  (opcode),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // Once the counter has reached the limit the held access is treated as if
  // mem_ready arrived, so that cycle is not a wait cycle.
  always_comb begin
    e_is_lw  = e_valid_q & (e_ctrl_q.wdata_src == WSRC_RAM);
    e_is_mem = e_is_lw | (e_valid_q & e_ctrl_q.ram_we);
    timeout  = (cnt_q == TO_MAX);
    mem_wait = e_is_mem & ~mem_ready & ~timeout;
    src_hit  = (e_waddr_q == opa)
             | ((e_waddr_q == opb) & ((opcode == OP_ALU) | (opcode == OP_SW)))
             | ((e_waddr_q == opd) & (opcode == OP_SW));
    hazard   = HAZARD_EN & e_is_lw & in_valid & src_hit;
    take     = ~reset & e_valid_q & e_ctrl_q.branch_op & (adata_zero != e_nz_q);
  end

  always_comb begin
    e_valid_d = 1'b0;
    e_ctrl_d  = '0;
    e_waddr_d = '0;
    e_nz_d    = 1'b0;
    e_ind_d   = 1'b0;
    illegal_d = 1'b0;
    cnt_d     = '0;
    if (mem_wait) begin
      e_valid_d = e_valid_q;
      e_ctrl_d  = e_ctrl_q;
      e_waddr_d = e_waddr_q;
      e_nz_d    = e_nz_q;
      e_ind_d   = e_ind_q;
      cnt_d     = timeout ? cnt_q : cnt_q + 1'b1;
    end else if (~take & ~hazard & in_valid) begin
      if (dec_illegal) begin
        illegal_d = 1'b1;
      end else begin
        e_valid_d = 1'b1;
        e_ctrl_d  = dec_ctrl;
        e_waddr_d = dec_ctrl.alu_altdest ? opb : opd;
        e_nz_d    = opfunc[3];
        e_ind_d   = opfunc[2];
      end
    end
    fault_d = fault_q | (mem_wait & (cnt_d == TO_MAX));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q <= 1'b0;
      e_ctrl_q  <= '0;
      e_waddr_q <= '0;
      e_nz_q    <= 1'b0;
      e_ind_q   <= 1'b0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      e_valid_q <= e_valid_d;
      e_ctrl_q  <= e_ctrl_d;
      e_waddr_q <= e_waddr_d;
      e_nz_q    <= e_nz_d;
      e_ind_q   <= e_ind_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready      = ~reset & ~mem_wait & ~hazard;
  assign stall         = mem_wait | hazard;
  assign branch_taken  = take;
  assign branch_ind    = take & e_ind_q;
  assign illegal       = illegal_q;
  assign mem_fault     = fault_q;
  assign e_valid       = e_valid_q;
  assign e_alu_pc      = e_ctrl_q.alu_pc;
  assign e_alu_imm     = e_ctrl_q.alu_imm;
  assign e_regs_we     = e_ctrl_q.regs_we;
  assign e_ram_we      = e_ctrl_q.ram_we;
  assign e_alu_altdest = e_ctrl_q.alu_altdest;
  assign e_wdata_src   = e_ctrl_q.wdata_src;
  assign e_waddr       = e_waddr_q;

endmodule

// File: tb/tb_control_pipe.sv
// Scoreboard bench for control_pipe: two instances (interlock on / off, different
// timeouts) share stimulus and are compared every cycle against a reference model.
module tb_control_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] opcode = '0, opfunc = '0, opd = '0, opa = '0, opb = '0;
  logic       adata_zero = 1'b0, mem_ready = 1'b1;

  typedef struct packed {
    logic       in_ready;
    logic       e_valid;
    logic       alu_pc;
    logic       alu_imm;
    logic       regs_we;
    logic       ram_we;
    logic       altdest;
    logic [1:0] wsrc;
    logic [3:0] waddr;
    logic       bt;
    logic       bi;
    logic       stall;
    logic       illegal;
    logic       fault;
  } obs_t;

  obs_t oh, on;

  control_pipe #(.RA_W(4), .HAZARD_EN(1'b1), .MEM_TIMEOUT(15)) dut_h (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(oh.in_ready),
    .opcode(opcode), .opfunc(opfunc), .opd(opd), .opa(opa), .opb(opb),
    .adata_zero(adata_zero), .mem_ready(mem_ready), .e_valid(oh.e_valid),
    .e_alu_pc(oh.alu_pc), .e_alu_imm(oh.alu_imm), .e_regs_we(oh.regs_we),
    .e_ram_we(oh.ram_we), .e_alu_altdest(oh.altdest), .e_wdata_src(oh.wsrc),
    .e_waddr(oh.waddr), .branch_taken(oh.bt), .branch_ind(oh.bi),
    .stall(oh.stall), .illegal(oh.illegal), .mem_fault(oh.fault)
  );

  control_pipe #(.RA_W(4), .HAZARD_EN(1'b0), .MEM_TIMEOUT(3)) dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(on.in_ready),
    .opcode(opcode), .opfunc(opfunc), .opd(opd), .opa(opa), .opb(opb),
    .adata_zero(adata_zero), .mem_ready(mem_ready), .e_valid(on.e_valid),
    .e_alu_pc(on.alu_pc), .e_alu_imm(on.alu_imm), .e_regs_we(on.regs_we),
    .e_ram_we(on.ram_we), .e_alu_altdest(on.altdest), .e_wdata_src(on.wsrc),
    .e_waddr(on.waddr), .branch_taken(on.bt), .branch_ind(on.bi),
    .stall(on.stall), .illegal(on.illegal), .mem_fault(on.fault)
  );

  // Reference model: the E slot is kept as the raw instruction it holds.
  typedef struct {
    bit       v;
    bit [3:0] op;
    bit [3:0] fn;
    bit [3:0] d;
  } ins_t;

  ins_t em[2];
  int   waits[2];
  bit   flt[2];
  bit   ill[2];
  int   to_lim[2] = '{15, 3};
  bit   hz_en[2]  = '{1'b1, 1'b0};

  obs_t q_h[$];
  obs_t q_n[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  function automatic obs_t model_step(input int k);
    obs_t x;
    bit   ev, is_lw, is_mem, wt, hz, br;
    x = '0;
    if (reset) begin
      em[k].v  = 1'b0;
      waits[k] = 0;
      flt[k]   = 1'b0;
      ill[k]   = 1'b0;
      return x;
    end
    ev     = em[k].v;
    is_lw  = ev && em[k].op == 4'd2;
    is_mem = ev && (em[k].op == 4'd2 || em[k].op == 4'd3);
    wt     = is_mem && !mem_ready && waits[k] != to_lim[k];
    hz     = hz_en[k] && is_lw && in_valid &&
             (em[k].d == opa ||
              (em[k].d == opb && (opcode == 4'd0 || opcode == 4'd3)) ||
              (em[k].d == opd && opcode == 4'd3));
    br     = ev && em[k].op == 4'd4 && (adata_zero != em[k].fn[3]);

    x.in_ready = !wt && !hz;
    x.stall    = wt || hz;
    x.bt       = br;
    x.bi       = br && em[k].fn[2];
    x.illegal  = ill[k];
    x.fault    = flt[k];
    x.e_valid  = ev;
    if (ev) begin
      x.waddr = em[k].d;
      case (em[k].op)
        4'd0: begin x.regs_we = 1; x.wsrc = 2'b00; end
        4'd1: begin x.alu_imm = 1; x.regs_we = 1; x.wsrc = 2'b00; end
        4'd2: begin x.alu_imm = 1; x.regs_we = 1; x.wsrc = 2'b01; end
        4'd3: begin x.alu_imm = 1; x.ram_we = 1; x.wsrc = 2'b11; end
        default: begin x.alu_pc = 1; x.alu_imm = 1; x.regs_we = 1; x.wsrc = 2'b10; end
      endcase
    end

    if (wt) begin
      waits[k] = waits[k] + 1;
      if (waits[k] == to_lim[k]) flt[k] = 1'b1;
      ill[k] = 1'b0;
    end else begin
      waits[k] = 0;
      ill[k]   = !br && !hz && in_valid && opcode > 4'd4;
      if (br || hz || !in_valid || opcode > 4'd4) em[k].v = 1'b0;
      else begin
        em[k].v  = 1'b1;
        em[k].op = opcode;
        em[k].fn = opfunc;
        em[k].d  = opd;
      end
    end
    return x;
  endfunction

  task automatic cyc(input bit r, input bit iv, input int op, input int fn,
                     input int d, input int a, input int b, input bit az, input bit mr);
    @(posedge clk);
    #1;
    reset      = r;
    in_valid   = iv;
    opcode     = op[3:0];
    opfunc     = fn[3:0];
    opd        = d[3:0];
    opa        = a[3:0];
    opb        = b[3:0];
    adata_zero = az;
    mem_ready  = mr;
    cyc_no++;
    q_h.push_back(model_step(0));
    q_n.push_back(model_step(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    obs_t ex;
    forever begin
      @(negedge clk);
      if (q_h.size() > 0) begin
        ex = q_h.pop_front();
        n_chk++;
        if (ex !== oh) begin
          n_bad++;
          $display("FAIL hzd_on cyc=%0d actual=%b expected=%b", cyc_no, oh, ex);
        end
      end
      if (q_n.size() > 0) begin
        ex = q_n.pop_front();
        n_chk++;
        if (ex !== on) begin
          n_bad++;
          $display("FAIL hzd_off cyc=%0d actual=%b expected=%b", cyc_no, on, ex);
        end
      end
    end
  end

  initial begin : stim
    int lo_run;
    bit r, iv, mr;
    int op;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);

    // reset in the middle of a SW wait
    cyc(0, 1, 3, 0, 1, 2, 3, 0, 1);
    cyc(0, 1, 0, 0, 1, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 2, 0, 0, 0, 1);
    idle(2);

    // back-to-back stream
    cyc(0, 1, 1, 0, 3, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 6, 3, 4, 0, 1);
    idle(2);

    // load-use, then store-data (opd) dependency
    cyc(0, 1, 2, 0, 5, 1, 1, 0, 1);
    cyc(0, 1, 0, 0, 7, 5, 1, 0, 1);
    cyc(0, 1, 0, 0, 7, 5, 1, 0, 1);
    cyc(0, 1, 2, 0, 6, 1, 1, 0, 1);
    cyc(0, 1, 3, 0, 6, 1, 2, 0, 1);
    cyc(0, 1, 3, 0, 6, 1, 2, 0, 1);
    idle(2);

    // branches: taken pc-relative, taken indirect, not taken
    cyc(0, 1, 4, 4'b0000, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 2, 0, 0, 1, 1);
    idle(1);
    cyc(0, 1, 4, 4'b1100, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 2, 0, 0, 0, 1);
    idle(1);
    cyc(0, 1, 4, 4'b1000, 1, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 2, 0, 0, 1, 1);
    idle(2);

    // SW waiting three cycles
    cyc(0, 1, 3, 0, 1, 2, 3, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8, 9, 10, 0, 0);
    cyc(0, 1, 0, 0, 8, 9, 10, 0, 1);
    idle(2);

    // SW never completing: timeout and sticky fault
    cyc(0, 1, 3, 0, 1, 2, 3, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 4, 0, 0, 0, 0);
    idle(4);

    // illegal opcode
    cyc(0, 1, 9, 0, 1, 1, 1, 0, 1);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);

    lo_run = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      iv = ($urandom_range(0, 3) != 0);
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(0, 4));
      if (lo_run == 0 && $urandom_range(0, 149) == 0) lo_run = 18;
      if (lo_run > 0) begin
        mr = 1'b0;
        lo_run--;
      end else begin
        mr = ($urandom_range(0, 3) != 0);
      end
      cyc(r, iv, op, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), mr);
    end

    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (q_h.size() != 0 || q_n.size() != 0) begin
      n_bad++;
      $display("FAIL drain actual=%0d/%0d pending expected=0/0", q_h.size(), q_n.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
